instr_loader: RTL and testbench

- Writer side of the instruction memory: fills an instruction RAM through its write port with a byte-serial program image.
- The image comes over a valid/ready byte stream, from a UART/JTAG bridge or a testbench.
- Holds the core in reset while loading; reports done or error when finished.
- Replaces $readmemb initialisation so benchmarks can be swapped without re-elaboration.

---
 rtl/instr_loader_pkg.sv | 31 +++
 rtl/instr_loader_packer.sv | 51 +++++
 rtl/instr_loader.sv | 146 ++++++++++++++
 tb/tb_instr_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared constants and state encoding for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

    localparam int INSTRUCT_MEM_SIZE = 1024;
    localparam int INSTRUCT_WORDS    = INSTRUCT_MEM_SIZE / 4;
    localparam int INSTRUCT_CNT_W    = $clog2(INSTRUCT_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    // Plain constants used by the FSM register; values track loader_state_t.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

endpackage

`default_nettype wire

// File: rtl/instr_loader_packer.sv
// ============================================================================
// Module      : byte_packer
// Description : Packs four bytes MSB-first into a 32-bit word; pulses
//               word_valid the cycle after the fourth byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 2'd0;
            r_word  <= 32'd0;
            r_valid <= 1'b0;
        end else if (clear) begin
            r_cnt   <= 2'd0;
            r_word  <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= byte_valid && (r_cnt == 2'd3);
            if (byte_valid) begin
                r_cnt  <= r_cnt + 2'd1;
                r_word <= {r_word[23:0], byte_data};
            end
        end
    end

    // High when the next accepted byte completes a word.
    assign byte_last  = (r_cnt == 2'd3);
    assign word_valid = r_valid;
    assign word       = r_word;

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module      : instr_loader
// Description : Fills instruction RAM from a byte stream while holding the
//               core in reset. Optional trailing checksum: INSTR_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_SIZE = INSTRUCT_MEM_SIZE,
    parameter int ADDR_W   = 64,
    parameter int CNT_W    = $clog2(MEM_SIZE / 4) + 1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [CNT_W-1:0] c_max_words = CNT_W'(MEM_SIZE / 4);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_after_load = ST_CHECK;
`else
    localparam logic [2:0] c_after_load = ST_DONE;
`endif

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic             r_final;

    logic             w_start_acc;
    logic             w_accept;
    logic             w_byte_last;
    logic             w_word_valid;
    logic [31:0]      w_word;
    logic             w_in_ready;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
    // r_final drops ready during the closing write so no byte of a next image slips in.
    assign w_in_ready  = ((r_state == ST_LOAD) || (r_state == ST_CHECK)) && !r_final;
    assign w_accept    = in_valid && w_in_ready;

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (w_start_acc),
        .byte_valid (w_accept),
        .byte_data  (in_data),
        .byte_last  (w_byte_last),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= 32'd0;
        end else if (w_start_acc) begin
            r_sum <= 32'd0;
        end else if (w_word_valid && (r_state == ST_LOAD)) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_idx   <= '0;
            r_final <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_start_acc) begin
                        r_num   <= num_words;
                        r_idx   <= '0;
                        r_final <= 1'b0;
                        if (num_words > c_max_words) begin
                            r_state <= ST_ERROR;
                        end else if (num_words == '0) begin
                            r_state <= c_after_load;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept && w_byte_last && (r_idx == r_num - c_one)) begin
                        r_final <= 1'b1;
                    end
                    if (w_word_valid) begin
                        r_idx <= r_idx + c_one;
                        if (r_final) begin
                            r_final <= 1'b0;
                            r_state <= c_after_load;
                        end
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept && w_byte_last) begin
                        r_final <= 1'b1;
                    end
                    if (w_word_valid) begin
                        r_final <= 1'b0;
                        r_state <= (w_word == r_sum) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_final <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign wr_en    = w_word_valid && (r_state == ST_LOAD);
    assign wr_addr  = {{(ADDR_W - CNT_W - 2){1'b0}}, r_idx, 2'b00};
    assign wr_data  = w_word;
    assign cpu_hold = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign done     = (r_state == ST_DONE);
    assign error    = (r_state == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module      : tb_instr_loader
// Description : Directed self-checking bench for instr_loader
//               (checksum steps enabled by INSTR_LOADER_CHECKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [8:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_writes = 0;

    instr_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en === 1'b1) n_writes++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] n);
        start     = 1'b1;
        num_words = n;
        tick();
        start     = 1'b0;
    endtask

    // Feed one word MSB-first; optionally idle a cycle after each byte.
    task automatic feed_word(input string tag, input logic [31:0] w, input bit gap,
                             input bit exp_wr, input logic [63:0] exp_addr, input bit is_last);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[31 - 8*i -: 8];
            tick();
            in_valid = 1'b0;
            if (i == 3) begin
                chk({tag, "_wr_en"}, 64'(wr_en), 64'(exp_wr));
                if (exp_wr) begin
                    chk({tag, "_addr"}, wr_addr, exp_addr);
                    chk({tag, "_data"}, 64'(wr_data), 64'(w));
                end
                chk({tag, "_ready"}, 64'(in_ready), 64'(!is_last));
                chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
            end else begin
                chk({tag, "_nowr"}, 64'(wr_en), 64'd0);
            end
            if (gap) begin
                tick();
                chk({tag, "_gap_nowr"}, 64'(wr_en), 64'd0);
            end
        end
    endtask

    task automatic finish_load(input string tag, input logic [31:0] sum);
`ifdef INSTR_LOADER_CHECKSUM_EN
        tick();
        chk({tag, "_chk_hold"}, 64'(cpu_hold), 64'd1);
        feed_word({tag, "_cksum"}, sum, 1'b0, 1'b0, 64'd0, 1'b1);
`else
        if (sum == 32'hFFFF_FFFF) $display("[TB] note: unusual checksum %0h", sum);
`endif
        tick();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(error), 64'd0);
        chk({tag, "_hold_off"}, 64'(cpu_hold), 64'd0);
        chk({tag, "_ready_off"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        num_words = '0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        #2;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addr", wr_addr, 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Two words back-to-back.
        pulse_start(9'd2);
        chk("t1_hold", 64'(cpu_hold), 64'd1);
        chk("t1_ready", 64'(in_ready), 64'd1);
        feed_word("t1_w0", 32'hE400_0091, 1'b0, 1'b1, 64'd0, 1'b0);
        feed_word("t1_w1", 32'h8B01_0002, 1'b0, 1'b1, 64'd4, 1'b1);
        finish_load("t1", 32'h6F01_0093);
        chk("t1_writes", 64'(n_writes), 64'd2);

        // Same image with in_valid toggling.
        pulse_start(9'd2);
        chk("t2_done_clr", 64'(done), 64'd0);
        feed_word("t2_w0", 32'hE400_0091, 1'b1, 1'b1, 64'd0, 1'b0);
        feed_word("t2_w1", 32'h8B01_0002, 1'b1, 1'b1, 64'd4, 1'b1);
        finish_load("t2", 32'h6F01_0093);
        chk("t2_writes", 64'(n_writes), 64'd4);

        // Oversized request.
        pulse_start(9'd257);
        chk("t3_err", 64'(error), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        chk("t3_hold", 64'(cpu_hold), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        chk("t3_writes", 64'(n_writes), 64'd4);

        // Reset in the middle of a 3-word load.
        pulse_start(9'd3);
        feed_word("t4_w0", 32'hCAFE_F00D, 1'b0, 1'b1, 64'd0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_data  = 8'h66;
        tick();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t4_rst_hold", 64'(cpu_hold), 64'd0);
        chk("t4_rst_ready", 64'(in_ready), 64'd0);
        chk("t4_rst_data", 64'(wr_data), 64'd0);
        chk("t4_rst_err", 64'(error), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start(9'd1);
        feed_word("t4_reload", 32'h1122_3344, 1'b0, 1'b1, 64'd0, 1'b1);
        finish_load("t4", 32'h1122_3344);
        chk("t4_writes", 64'(n_writes), 64'd6);

        // Zero-word load.
        pulse_start(9'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        chk("t5_zero_hold", 64'(cpu_hold), 64'd1);
        feed_word("t5_zero_ck", 32'h0000_0000, 1'b0, 1'b0, 64'd0, 1'b1);
        tick();
`endif
        chk("t5_zero_done", 64'(done), 64'd1);
        chk("t5_zero_hold_off", 64'(cpu_hold), 64'd0);
        chk("t5_zero_writes", 64'(n_writes), 64'd6);

        // start during LOAD is ignored.
        pulse_start(9'd1);
        in_valid = 1'b1;
        in_data  = 8'hDE;
        tick();
        in_data  = 8'hAD;
        start    = 1'b1;
        num_words = 9'd0;
        tick();
        start    = 1'b0;
        in_data  = 8'hBE;
        tick();
        in_data  = 8'hEF;
        tick();
        in_valid = 1'b0;
        chk("t5_ign_wr", 64'(wr_en), 64'd1);
        chk("t5_ign_addr", wr_addr, 64'd0);
        chk("t5_ign_data", 64'(wr_data), 64'hDEAD_BEEF);
        finish_load("t5_ign", 32'hDEAD_BEEF);
        chk("t5_writes", 64'(n_writes), 64'd7);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Good and bad checksums.
        pulse_start(9'd2);
        feed_word("t6_w0", 32'h0000_0001, 1'b0, 1'b1, 64'd0, 1'b0);
        feed_word("t6_w1", 32'h0000_0002, 1'b0, 1'b1, 64'd4, 1'b1);
        finish_load("t6", 32'h0000_0003);
        pulse_start(9'd2);
        feed_word("t7_w0", 32'h0000_0001, 1'b0, 1'b1, 64'd0, 1'b0);
        feed_word("t7_w1", 32'h0000_0002, 1'b0, 1'b1, 64'd4, 1'b1);
        tick();
        feed_word("t7_cksum", 32'h0000_0004, 1'b0, 1'b0, 64'd0, 1'b1);
        tick();
        chk("t7_err", 64'(error), 64'd1);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_writes", 64'(n_writes), 64'd11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
